// File: rtl/bmp_ram_arbiter_pkg.sv
// bmp_ram_arbiter_pkg: shared definitions for the BMP image RAM arbiter.
// Holds the default widths, the default grant-length limit and the arbiter
// FSM state encoding.
package bmp_ram_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_MAX_HOLD   = 1024;
  localparam int ID_WIDTH       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bmp_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. The winner is the first set
// request bit at or above ptr_i, otherwise the lowest set bit overall,
// which is the same as searching upward from ptr_i modulo NUM_REQ.
module rr_pick
  import bmp_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [PTR_W-1:0]   win_idx_o,
  output logic               win_valid_o
);

  localparam logic [NUM_REQ-1:0] ONE_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] idx_any_s;
  logic [PTR_W-1:0] idx_hi_s;
  logic             hit_hi_s;
  logic             hi_s;

  // Scan downward so the lowest qualifying index is the one left standing.
  always_comb begin
    idx_any_s = {PTR_W{1'b0}};
    idx_hi_s  = {PTR_W{1'b0}};
    hit_hi_s  = 1'b0;
    hi_s      = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      hi_s      = req_i[j] && (j >= int'(ptr_i));
      idx_any_s = req_i[j] ? PTR_W'(j) : idx_any_s;
      idx_hi_s  = hi_s ? PTR_W'(j) : idx_hi_s;
      hit_hi_s  = hit_hi_s | hi_s;
    end
    win_valid_o  = |req_i;
    win_idx_o    = hit_hi_s ? idx_hi_s : idx_any_s;
    win_onehot_o = win_valid_o ? (ONE_LSB << win_idx_o) : {NUM_REQ{1'b0}};
  end

endmodule

// File: rtl/bmp_ram_arbiter.sv
// bmp_ram_arbiter: round-robin owner of the shared byte-wide BMP image RAM.
// One stage at a time holds a registered one-hot grant; its strobes, address
// and write data are muxed onto the RAM port. Every grant is followed by a
// one-cycle RELEASE turnaround before the next arbitration.
// Optional feature macro: ARB_TIMEOUT_EN (revoke a grant after MAX_HOLD
// cycles and report it through timeout/timeout_id).
module bmp_ram_arbiter
  import bmp_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_ren,
  input  logic [NUM_REQ-1:0]            req_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_wdata,
  input  logic [BYTE_WIDTH-1:0]         RAM_out,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [BYTE_WIDTH-1:0]         rdata,
  output logic                          RAM_ren,
  output logic                          RAM_wen,
  output logic [ADDR_WIDTH-1:0]         RAM_addr,
  output logic [BYTE_WIDTH-1:0]         RAM_in,
  output logic                          busy,
  output logic                          timeout,
  output logic [ID_WIDTH-1:0]           timeout_id
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_oh_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic               pick_valid_s;
  logic [PTR_W-1:0]   nxt_idx_s;
  logic               req_g_s;
  logic               hold_hit_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_o (pick_oh_s),
    .win_idx_o    (pick_idx_s),
    .win_valid_o  (pick_valid_s)
  );

  // Request bit of the current owner; only meaningful while gnt_q is set.
  assign req_g_s   = req[gidx_q];
  // Rotation point after the current owner leaves.
  assign nxt_idx_s = (gidx_q == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : gidx_q + PTR_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic [ID_WIDTH-1:0] timeout_id_q, timeout_id_d;

  assign hold_hit_s = (state_q == ST_GRANT) && req_g_s && (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Hold counter is zero outside GRANT and counts each GRANT cycle.
  always_comb begin
    hold_d       = (state_q == ST_GRANT) ? hold_q + HOLD_W'(1) : {HOLD_W{1'b0}};
    timeout_d    = hold_hit_s;
    timeout_id_d = hold_hit_s ? ID_WIDTH'(gidx_q) : timeout_id_q;
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= {HOLD_W{1'b0}};
      timeout_q    <= 1'b0;
      timeout_id_q <= {ID_WIDTH{1'b0}};
    end else begin
      hold_q       <= hold_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;
`else
  assign hold_hit_s = 1'b0;
  assign timeout    = 1'b0;
  assign timeout_id = {ID_WIDTH{1'b0}};
`endif

  // Arbitration FSM: next state, grant, owner index and rotation pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh_s;
          gidx_d  = pick_idx_s;
        end else begin
          gnt_d   = {NUM_REQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!req_g_s || hold_hit_s) begin
          state_d = ST_RELEASE;
          gnt_d   = {NUM_REQ{1'b0}};
          ptr_d   = nxt_idx_s;
        end else begin
          gnt_d   = gnt_q;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
      end
    endcase
    busy_d = |gnt_d;
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {PTR_W{1'b0}};
      gidx_q  <= {PTR_W{1'b0}};
      gnt_q   <= {NUM_REQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // RAM port mux from the registered grant; strobes also need the live req
  // so they fall in the same cycle the owner drops its request.
  always_comb begin
    if (|gnt_q) begin
      RAM_wen  = req_g_s & req_wen[gidx_q];
      RAM_ren  = req_g_s & req_ren[gidx_q] & ~req_wen[gidx_q];
      RAM_addr = req_addr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      RAM_in   = req_wdata[gidx_q*BYTE_WIDTH +: BYTE_WIDTH];
    end else begin
      RAM_wen  = 1'b0;
      RAM_ren  = 1'b0;
      RAM_addr = {ADDR_WIDTH{1'b0}};
      RAM_in   = {BYTE_WIDTH{1'b0}};
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign rdata = RAM_out;

endmodule

// File: tb/tb_bmp_ram_arbiter.sv
// tb_bmp_ram_arbiter: randomized and directed stimulus for bmp_ram_arbiter.
// A transaction-level reference model (owner / turnaround gap / rotation
// start) predicts every cycle's outputs; predictions go into a queue that a
// separate monitor drains and compares against the DUT.
module tb_bmp_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int BW = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 8;
  localparam bit TO_EN       = 1'b1;
  localparam int HOLD_CYC    = 40;
`else
  localparam int TB_MAX_HOLD = 1024;
  localparam bit TO_EN       = 1'b0;
  localparam int HOLD_CYC    = 2000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_ren, req_wen;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_wdata;
  logic [BW-1:0]   RAM_out;
  logic [N-1:0]    gnt;
  logic [BW-1:0]   rdata;
  logic            RAM_ren, RAM_wen;
  logic [AW-1:0]   RAM_addr;
  logic [BW-1:0]   RAM_in;
  logic            busy, timeout;
  logic [2:0]      timeout_id;

  bmp_ram_arbiter #(
    .NUM_REQ(N), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_HOLD(TB_MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .RAM_out(RAM_out),
    .gnt(gnt), .rdata(rdata), .RAM_ren(RAM_ren), .RAM_wen(RAM_wen),
    .RAM_addr(RAM_addr), .RAM_in(RAM_in), .busy(busy),
    .timeout(timeout), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          busy;
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [BW-1:0] din;
    logic [BW-1:0] rdata;
    logic          to;
    logic [2:0]    toid;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: owner (-1 = none), granted cycles completed,
  // turnaround cycles still to wait, first index of the next search.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_nxt   = 0;
  bit m_to    = 1'b0;
  int m_toid  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = '0;
    e.wen  = 1'b0;
    e.ren  = 1'b0;
    e.addr = '0;
    e.din  = '0;
    if (m_owner >= 0) begin
      e.gnt  = 4'd1 << m_owner;
      e.wen  = req[m_owner] && req_wen[m_owner];
      e.ren  = req[m_owner] && req_ren[m_owner] && !req_wen[m_owner];
      e.addr = req_addr[m_owner*AW +: AW];
      e.din  = req_wdata[m_owner*BW +: BW];
    end
    e.busy  = (m_owner >= 0);
    e.rdata = RAM_out;
    e.to    = m_to;
    e.toid  = 3'(m_toid);
    return e;
  endfunction

  // Model step on every rising edge, from the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_nxt = 0; m_to = 1'b0; m_toid = 0;
      chk_en  = 1'b1;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (!req[m_owner] || (TO_EN && m_held >= TB_MAX_HOLD)) begin
          if (req[m_owner]) begin
            m_to   = 1'b1;
            m_toid = m_owner;
          end
          m_nxt   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_nxt + k) % N]) begin
            m_owner = (m_nxt + k) % N;
            m_held  = 0;
          end
        end
      end
    end
  end

  // Monitor: compare whatever the DUT presents this cycle with the prediction.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("gnt",        32'(gnt),        32'(cur.gnt));
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      check("busy",       32'(busy),       32'(cur.busy));
      check("RAM_wen",    32'(RAM_wen),    32'(cur.wen));
      check("RAM_ren",    32'(RAM_ren),    32'(cur.ren));
      check("RAM_addr",   32'(RAM_addr),   32'(cur.addr));
      check("RAM_in",     32'(RAM_in),     32'(cur.din));
      check("rdata",      32'(rdata),      32'(cur.rdata));
      check("timeout",    32'(timeout),    32'(cur.to));
      check("timeout_id", 32'(timeout_id), 32'(cur.toid));
    end
  end

  task automatic drive(input bit r, input logic [N-1:0] rq, input logic [N-1:0] rn,
                       input logic [N-1:0] wn, input logic [N*AW-1:0] ad,
                       input logic [N*BW-1:0] wd);
    @(negedge clk);
    rst = r; req = rq; req_ren = rn; req_wen = wn; req_addr = ad; req_wdata = wd;
    RAM_out = 8'($urandom);
    #1;
    if (chk_en) exp_q.push_back(model_out());
  endtask

  function automatic logic [N*AW-1:0] rnd_addr();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = 20'($urandom);
    return a;
  endfunction

  logic [N*AW-1:0] ad;
  logic [N*BW-1:0] wd;
  logic [N-1:0]    want, done, prev_g;
  int              wr, zrun, first_seen;
  int              order[$];
  int              gaps[$];

  initial begin
    rst = 1'b1; req = '0; req_ren = '0; req_wen = '0;
    req_addr = '0; req_wdata = '0; RAM_out = '0;

    // Reset state.
    repeat (3) drive(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0);

    // Single requester 1: five writes to 0x36..0x3A.
    wr = 0;
    for (int c = 0; c < 20 && wr < 5; c++) begin
      ad = rnd_addr();
      ad[1*AW +: AW] = 20'h36 + 20'(wr);
      wd = N*BW'($urandom);
      drive(1'b0, 4'b0010, 4'b0000, 4'b0010, ad, wd);
      if (RAM_wen === 1'b1) wr++;
    end
    check("write_pulses", 32'(wr), 32'd5);
    repeat (3) drive(1'b0, 4'b0000, 4'b0011, 4'b0011, rnd_addr(), '0);

    // Both strobes from the owner; requester 0 strobes without a grant.
    repeat (6) drive(1'b0, 4'b0100, 4'b0101, 4'b0101, rnd_addr(), {8'h00, 8'hFF, 8'h00, 8'h5A});
    repeat (3) drive(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0);

    // All four requesting from reset, each leaving after three granted cycles.
    repeat (2) drive(1'b1, 4'b1111, 4'b0000, 4'b0000, '0, '0);
    done = '0; prev_g = '0; zrun = 0; first_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_owner >= 0 && m_held == 3) done[m_owner] = 1'b1;
      drive(1'b0, ~done, 4'b1111, 4'b0000, rnd_addr(), N*BW'($urandom));
      if (gnt == '0) begin
        zrun++;
      end else if (gnt != prev_g) begin
        for (int i = N - 1; i >= 0; i--) if (gnt[i]) first_seen = i;
        order.push_back(first_seen);
        if (order.size() > 1) gaps.push_back(zrun);
        zrun = 0;
      end
      prev_g = gnt;
    end
    check("order_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size() && k < N; k++) check("grant_order", 32'(order[k]), 32'(k));
    for (int k = 0; k < gaps.size(); k++) check("burst_gap", 32'(gaps[k]), 32'd2);

    // Reset mid-burst, then re-arbitration starts from requester 0.
    repeat (4) drive(1'b0, 4'b1000, 4'b1000, 4'b1000, rnd_addr(), N*BW'($urandom));
    drive(1'b1, 4'b1001, 4'b1001, 4'b1001, rnd_addr(), N*BW'($urandom));
    repeat (5) drive(1'b0, 4'b1001, 4'b1001, 4'b0000, rnd_addr(), N*BW'($urandom));
    repeat (3) drive(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0);

    // Randomized bursts with occasional reset.
    want = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) want[i] = ~want[i];
      drive(($urandom_range(0, 99) == 0), want, 4'($urandom), 4'($urandom),
            rnd_addr(), N*BW'($urandom));
    end

    // Long hold by requester 2 with requester 3 waiting.
    repeat (2) drive(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0);
    for (int c = 0; c < HOLD_CYC; c++)
      drive(1'b0, 4'b1100, 4'($urandom), 4'($urandom), rnd_addr(), N*BW'($urandom));
    repeat (4) drive(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0);

    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
